// File: rtl/sci_frame_ctrl.sv
// SCI receive frame controller: delimits frames on the K line, writes payload
// bytes to the data FIFO and one {ovf, trunc, len} descriptor per frame.
module sci_frame_ctrl #(
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned LEN_W   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               k,
    input  logic               valid_in,
    input  logic [7:0]         din,
    input  logic               data_full,
    output logic               data_wr,
    output logic [7:0]         data_wdata,
    input  logic               desc_full,
    output logic               desc_wr,
    output logic [LEN_W+1:0]   desc_wdata,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        drop_cnt
);

    localparam int unsigned DESC_W = LEN_W + 2;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        RECV,
        DISCARD,
        CLOSE
    } state_t;

    state_t              state, state_d;
    logic                k_r;
    logic [LEN_W-1:0]    len, len_d;
    logic                trunc, trunc_d;
    logic                ovf, ovf_d;
    logic                data_wr_d;
    logic [7:0]          data_wdata_d;
    logic                desc_wr_d;
    logic [DESC_W-1:0]   desc_wdata_d;
    logic [15:0]         frame_cnt_d;
    logic [15:0]         drop_cnt_d;
    logic                neg_k;
    logic                pos_k;
    logic                recv_en;

    assign neg_k = !k && k_r;
    assign pos_k = k && !k_r;

    // Next-state, byte acceptance and descriptor generation
    always_comb begin
        state_d      = state;
        len_d        = len;
        trunc_d      = trunc;
        ovf_d        = ovf;
        data_wr_d    = 1'b0;
        data_wdata_d = data_wdata;
        desc_wr_d    = 1'b0;
        desc_wdata_d = desc_wdata;
        frame_cnt_d  = frame_cnt;
        drop_cnt_d   = drop_cnt;
        recv_en      = 1'b0;

        case (state)
            SYNC: begin
                if (k) state_d = IDLE;
            end
            IDLE, CLOSE: begin
                if (state == CLOSE) begin
                    state_d = IDLE;
                    // Empty frames (no bytes, no flags) produce no descriptor
                    if (len != '0 || trunc || ovf) begin
                        desc_wr_d    = 1'b1;
                        desc_wdata_d = {ovf, trunc, len};
                        if (frame_cnt != 16'hFFFF) frame_cnt_d = frame_cnt + 16'd1;
                    end
                end
                if (neg_k) begin
                    if (!desc_full) begin
                        state_d = RECV;
                        len_d   = '0;
                        trunc_d = 1'b0;
                        ovf_d   = 1'b0;
                        recv_en = 1'b1;
                    end else begin
                        state_d = DISCARD;
                        if (drop_cnt != 16'hFFFF) drop_cnt_d = drop_cnt + 16'd1;
                    end
                end
            end
            RECV: begin
                recv_en = 1'b1;
                if (pos_k) state_d = CLOSE;
            end
            DISCARD: begin
                if (pos_k) state_d = IDLE;
            end
            default: state_d = SYNC;
        endcase

        // Truncation takes priority over overflow; overflowed bytes do not count
        if (recv_en && valid_in && !k) begin
            if (len_d == LEN_W'(MAX_LEN)) begin
                trunc_d = 1'b1;
            end else if (data_full) begin
                ovf_d = 1'b1;
            end else begin
                data_wr_d    = 1'b1;
                data_wdata_d = din;
                len_d        = len_d + LEN_W'(1);
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            k_r        <= 1'b0;
            len        <= '0;
            trunc      <= 1'b0;
            ovf        <= 1'b0;
            data_wr    <= 1'b0;
            data_wdata <= 8'h00;
            desc_wr    <= 1'b0;
            desc_wdata <= '0;
            frame_cnt  <= 16'h0000;
            drop_cnt   <= 16'h0000;
        end else begin
            state      <= state_d;
            k_r        <= k;
            len        <= len_d;
            trunc      <= trunc_d;
            ovf        <= ovf_d;
            data_wr    <= data_wr_d;
            data_wdata <= data_wdata_d;
            desc_wr    <= desc_wr_d;
            desc_wdata <= desc_wdata_d;
            frame_cnt  <= frame_cnt_d;
            drop_cnt   <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_sci_frame_ctrl.sv
// Scoreboard bench for sci_frame_ctrl: frame-level expectations are queued as
// stimulus is driven and popped as the DUT writes data bytes and descriptors.
module tb_sci_frame_ctrl;

    localparam int unsigned MAX_LEN = 256;
    localparam int unsigned LEN_W   = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              k;
    logic              valid_in;
    logic [7:0]        din;
    logic              data_full;
    logic              data_wr;
    logic [7:0]        data_wdata;
    logic              desc_full;
    logic              desc_wr;
    logic [LEN_W+1:0]  desc_wdata;
    logic [15:0]       frame_cnt;
    logic [15:0]       drop_cnt;

    logic [7:0]        data_q[$];
    logic [LEN_W+1:0]  desc_q[$];
    int                checks = 0;
    int                failures = 0;
    int                exp_frames = 0;
    int                exp_drops = 0;

    sci_frame_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .k          (k),
        .valid_in   (valid_in),
        .din        (din),
        .data_full  (data_full),
        .data_wr    (data_wr),
        .data_wdata (data_wdata),
        .desc_full  (desc_full),
        .desc_wr    (desc_wr),
        .desc_wdata (desc_wdata),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One input cycle: apply, clock, settle past the edge
    task automatic drive(input logic kk, input logic vv, input logic [7:0] dd, input logic df);
        k         = kk;
        valid_in  = vv;
        din       = dd;
        data_full = df;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // Frame starting with a byte in the neg_k cycle and ending with a pos_k cycle.
    // data_full is high for byte indices flo..fhi; drop holds desc_full at frame start.
    task automatic send_frame(input int n, input logic [7:0] base, input int flo,
                              input int fhi, input bit drop);
        int          cnt;
        bit          tr;
        bit          ov;
        logic [7:0]  b;
        logic        full;
        cnt = 0;
        tr  = 1'b0;
        ov  = 1'b0;
        for (int i = 0; i < n; i++) begin
            b         = 8'(int'(base) + i);
            full      = (i >= flo) && (i <= fhi);
            desc_full = drop && (i == 0);
            if (!drop) begin
                if (cnt == int'(MAX_LEN)) tr = 1'b1;
                else if (full) ov = 1'b1;
                else begin
                    data_q.push_back(b);
                    cnt++;
                end
            end
            drive(1'b0, 1'b1, b, full);
        end
        desc_full = 1'b0;
        if (drop) exp_drops++;
        else if (cnt != 0 || tr || ov) begin
            desc_q.push_back({ov, tr, LEN_W'(cnt)});
            exp_frames++;
        end
        drive(1'b1, 1'b1, 8'hEE, 1'b0);
    endtask

    // Scoreboard monitor on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_wr) begin
                if (data_q.size() == 0) check_eq("data_unexpected", 32'(data_wdata), 32'hFFFF_FFFF);
                else check_eq("data_byte", 32'(data_wdata), 32'(data_q.pop_front()));
            end
            if (desc_wr) begin
                if (desc_q.size() == 0) check_eq("desc_unexpected", 32'(desc_wdata), 32'hFFFF_FFFF);
                else check_eq("desc_word", 32'(desc_wdata), 32'(desc_q.pop_front()));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data_wr"},    32'(data_wr),    32'd0);
        check_eq({tag, "_data_wdata"}, 32'(data_wdata), 32'd0);
        check_eq({tag, "_desc_wr"},    32'(desc_wr),    32'd0);
        check_eq({tag, "_desc_wdata"}, 32'(desc_wdata), 32'd0);
        check_eq({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
        check_eq({tag, "_drop_cnt"},   32'(drop_cnt),   32'd0);
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        check_eq({tag, "_drop_cnt"},  32'(drop_cnt),  32'(exp_drops));
    endtask

    initial begin
        rst_n     = 1'b0;
        k         = 1'b0;
        valid_in  = 1'b1;
        din       = 8'h55;
        data_full = 1'b0;
        desc_full = 1'b0;

        // Reset while a frame streams, then the in-progress frame must be ignored
        repeat (2) drive(1'b0, 1'b1, 8'h5A, 1'b0);
        check_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        idle(3);
        send_frame(4, 8'h11, -1, -1, 1'b0);
        idle(3);
        check_counts("basic");

        // Oversize frame truncated at MAX_LEN
        send_frame(300, 8'h00, -1, -1, 1'b0);
        idle(3);
        check_counts("trunc");

        // Data FIFO full for bytes 3..5
        send_frame(10, 8'hA0, 2, 4, 1'b0);
        idle(3);
        check_counts("ovf");

        // Descriptor FIFO full at frame start: whole frame dropped
        send_frame(6, 8'hB0, -1, -1, 1'b1);
        idle(3);
        check_counts("drop");
        send_frame(3, 8'hC0, -1, -1, 1'b0);
        idle(3);
        check_counts("after_drop");

        // Empty frame writes no descriptor
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'hFF, 1'b0);
        idle(3);
        check_counts("empty");

        // Back-to-back frames separated by a single K cycle
        send_frame(2, 8'h21, -1, -1, 1'b0);
        send_frame(2, 8'h31, -1, -1, 1'b0);
        idle(3);
        check_counts("b2b");

        // Reset mid-frame clears outputs at once; block resyncs on next K
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 8'h00, 1'b0);
            data_q.push_back(8'(8'hD0 + i));
            drive(1'b0, 1'b1, 8'(8'hD0 + i), 1'b0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_frames = 0;
        exp_drops  = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'(8'hD3 + i), 1'b0);
        check_eq("sync_no_write", 32'(data_wr), 32'd0);
        idle(2);
        send_frame(2, 8'hE0, -1, -1, 1'b0);
        idle(3);
        check_counts("resync");

        idle(2);
        check_eq("data_q_left", 32'(data_q.size()), 32'd0);
        check_eq("desc_q_left", 32'(desc_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sci_frame_ctrl.md
# sci_frame_ctrl

Receive-side frame controller for the SCI link. Sits after the byte decoder and before the receive data FIFO and descriptor FIFO. Uses the K-character line to delimit frames, writes accepted payload bytes into the data FIFO, and writes one length/status descriptor per frame. Handles oversize frames, data-FIFO overflow and descriptor-FIFO back-pressure deterministically.

## Interface
Parameters:
- MAX_LEN, 256: maximum payload bytes written per frame.
- LEN_W, 9: byte-counter width; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- k  in  1  K-character indicator; high = inter-frame gap, low = frame body.
- valid_in  in  1  din carries a decoded byte this cycle.
- din  in  8  decoded byte.
- data_full  in  1  data FIFO full.
- data_wr  out  1  data FIFO write strobe.
- data_wdata  out  8  data FIFO write data.
- desc_full  in  1  descriptor FIFO full.
- desc_wr  out  1  descriptor FIFO write strobe.
- desc_wdata  out  LEN_W+2  {ovf, trunc, len[LEN_W-1:0]}.
- frame_cnt  out  16  descriptors written; saturates at 16'hFFFF.
- drop_cnt  out  16  frames discarded whole; saturates at 16'hFFFF.

## Operation
- k_r is k delayed by one cycle; reset value 0. neg_k = !k && k_r; pos_k = k && !k_r.
- Byte accepted in a cycle when state is RECV, or when neg_k is honored that cycle, and valid_in=1 and k=0.
- States:
  - SYNC: reset state. Ignores all input. Goes to IDLE when k=1, so a frame already in progress at reset is never captured.
  - IDLE: waits for neg_k.
    - If desc_full=0: go to RECV. Clear len, trunc and ovf. Process that cycle's byte.
    - If desc_full=1: go to DISCARD and increment drop_cnt.
  - RECV: for each accepted byte:
    - len == MAX_LEN: byte not written, trunc set.
    - else data_full=1: byte not written, ovf set, len unchanged.
    - else: byte written, len+1.
    - On pos_k go to CLOSE.
  - DISCARD: no writes. On pos_k go to IDLE.
  - CLOSE: lasts one cycle.
    - If len != 0 or trunc or ovf: desc_wr=1, desc_wdata={ovf,trunc,len}, frame_cnt+1.
    - Otherwise (empty frame) no descriptor is written.
    - If neg_k occurs in the CLOSE cycle, it is handled exactly as in IDLE (same cycle, same desc_full check); otherwise go to IDLE.
- Descriptor slot guarantee: this block is the only writer of the descriptor FIFO. desc_full=0 at frame start therefore guarantees space at CLOSE.
- data_wdata holds the last written byte when data_wr=0.

## Timing
- Reset values: data_wr=0, data_wdata=0, desc_wr=0, desc_wdata=0, frame_cnt=0, drop_cnt=0, state SYNC, len=0.
- All outputs are registered. data_wr/data_wdata assert one cycle after the byte is accepted.
- The first byte may arrive in the neg_k cycle itself. A byte presented in the pos_k cycle is not accepted (k=1).
- desc_wr asserts in the cycle after the CLOSE cycle, i.e. two cycles after pos_k is sampled. The last data_wr always precedes or coincides with desc_wr.
- Strobes are single-cycle pulses. Counters update in the same cycle as the related strobe (frame_cnt) or the discard decision (drop_cnt).
- rst_n asserted mid-frame: everything returns to reset values immediately. After release the block must see k=1 before accepting a frame. A partial frame already in the FIFO is the consumer's concern.

## Test plan
- Reset with k=0 and valid bytes streaming, then k=1, then a 4-byte frame 0x11..0x14 -> no writes before the first k=1; then 4 data_wr with 0x11..0x14 and desc_wdata={0,0,4}; frame_cnt=1.
- 300-byte frame with MAX_LEN=256 -> exactly 256 data_wr; descriptor {0,1,256}.
- data_full high for bytes 3-5 of a 10-byte frame -> 7 data_wr; descriptor {1,0,7}.
- desc_full=1 at neg_k, deasserted mid-frame -> no data_wr, no desc_wr; drop_cnt=1; the next frame is captured normally.
- Empty frame (k low 5 cycles, valid_in=0) -> no desc_wr; frame_cnt unchanged. A k=1 gap of one cycle between two 2-byte frames -> two descriptors {0,0,2}, and all 4 bytes in order.
- rst_n pulsed mid-frame -> all outputs 0 the same cycle; the block stays in SYNC until k=1.
